// File: rtl/fetch_entry_queue.sv
// Fetch entry queue: FWFT buffer between frontend and decode.
// Accepting an exception entry blocks further pushes until flush.
package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32};
endpackage

package ariane_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  cause;
    logic [31:0] tval;
  } exception_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] instruction;
    exception_t  ex;
  } fetch_entry_t;
endpackage

module fetch_entry_queue #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic [$bits(ariane_pkg::fetch_entry_t)-1:0] fetch_entry_i,
  input  logic fetch_entry_valid_i,
  output logic fetch_entry_ready_o,
  output logic [$bits(ariane_pkg::fetch_entry_t)-1:0] fetch_entry_o,
  output logic fetch_entry_valid_o,
  input  logic fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0] usage_o,
  output logic ex_hold_o
);
  import ariane_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  localparam logic STATE_RUN     = 1'b0;
  localparam logic STATE_EX_HOLD = 1'b1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      CVA6Cfg.XLEN == 0) begin : g_bad_cfg
    $error("fetch_entry_queue: illegal DEPTH or configuration");
  end

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t entry_in;

  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   usage_q;
  logic          state_q;
  logic          push, pop;

  assign entry_in = fetch_entry_t'(fetch_entry_i);

  // rst_ni gates the handshakes so nothing moves while reset is low
  assign fetch_entry_ready_o = rst_ni && (usage_q != FULL) &&
                               (state_q == STATE_RUN);
  assign fetch_entry_valid_o = rst_ni && (usage_q != '0) && !flush_i;

  assign push = fetch_entry_valid_i && fetch_entry_ready_o && !flush_i;
  assign pop  = fetch_entry_valid_o && fetch_entry_ready_i;

  assign fetch_entry_o = mem_q[head_q];
  assign usage_o       = usage_q;
  assign ex_hold_o     = (state_q == STATE_EX_HOLD);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      usage_q <= '0;
      state_q <= STATE_RUN;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   usage_q <= usage_q + 1'b1;
        2'b01:   usage_q <= usage_q - 1'b1;
        default: usage_q <= usage_q;
      endcase
      if (push && entry_in.ex.valid) state_q <= STATE_EX_HOLD;
    end
  end

  // storage is deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[tail_q] <= entry_in;
  end
endmodule

// File: doc/fetch_entry_queue.md
FETCH_ENTRY_QUEUE -- requirements
Module: fetch_entry_queue

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, meaning the core configuration.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the entry count. Legal values are powers of two, 2 to 16.
REQ-003 SHALL have one clock and a synchronous, active-low reset, as the following two lines state.
REQ-004 clk_i  input  1  clock; all state changes on the rising edge.
REQ-005 rst_ni  input  1  reset; synchronous, active-low.
REQ-006 flush_i  input  1  discards all entries.
REQ-007 fetch_entry_i  input  $bits(ariane_pkg::fetch_entry_t)  entry from the frontend.
REQ-008 fetch_entry_valid_i  input  1  fetch_entry_i is valid.
REQ-009 fetch_entry_ready_o  output  1  the queue can accept an entry.
REQ-010 fetch_entry_o  output  $bits(ariane_pkg::fetch_entry_t)  head entry, driven to the decode stage.
REQ-011 fetch_entry_valid_o  output  1  fetch_entry_o is valid.
REQ-012 fetch_entry_ready_i  input  1  decode accepts the head entry.
REQ-013 usage_o  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
REQ-014 ex_hold_o  output  1  an exception entry has been accepted and further pushes are blocked.

Function
REQ-015 SHALL implement a first-word-fall-through FIFO: fetch_entry_o shows the head entry combinationally, and valid_o = (usage_o != 0) && !flush_i.
REQ-016 A push SHALL occur when fetch_entry_valid_i && fetch_entry_ready_o && !flush_i; the entry is written at the tail and the tail pointer advances modulo DEPTH.
REQ-017 A pop SHALL occur when fetch_entry_valid_o && fetch_entry_ready_i; the head pointer advances modulo DEPTH.
REQ-018 Push latency SHALL be 1 cycle: an entry pushed in an empty queue at cycle N appears on fetch_entry_o with valid_o=1 at cycle N+1.
REQ-019 fetch_entry_ready_o SHALL be (usage_o < DEPTH) && state==RUN, from registered state only, with no combinational path from fetch_entry_ready_i.
REQ-020 A simultaneous push and pop SHALL leave usage_o unchanged, and entry order SHALL be preserved.
REQ-021 When full, no push SHALL occur even if a pop happens in the same cycle; the freed slot becomes available the next cycle.
REQ-022 Pointers SHALL be $clog2(DEPTH) bits wide and wrap with no special case. usage_o SHALL be a separate counter, never exceeding DEPTH and never going below 0.
REQ-023 The state machine SHALL have two states, RUN and EX_HOLD.
REQ-024 RUN -> EX_HOLD SHALL occur on a push whose entry has ex.valid=1.
REQ-025 EX_HOLD -> RUN SHALL occur only on flush_i or reset. ex_hold_o = (state==EX_HOLD).
REQ-026 In EX_HOLD, entries already queued, including the exception entry, SHALL continue to drain normally.
REQ-027 flush_i SHALL take effect in the same cycle: valid_o=0 and no push or pop takes effect. Next cycle: usage_o=0, head=tail=0, state RUN.
REQ-028 flush_i SHALL have priority over push, pop and the state transition in the same cycle.
REQ-029 Storage contents SHALL NOT be reset or cleared; only pointers, counter and state are.

Reset
REQ-030 While rst_ni=0 at a rising edge, the next state SHALL be: usage_o=0, head=tail=0, state RUN.
REQ-031 While rst_ni=0, fetch_entry_valid_o=0 and fetch_entry_ready_o=0 SHALL hold combinationally.
REQ-032 After reset is released, outputs SHALL be valid_o=0, ready_o=1, usage_o=0, ex_hold_o=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries identically to flush, with reset taking priority over flush.

Verification
REQ-034 Fill/drain, DEPTH=4, ready_i=0: push addresses 0x80,0x84,0x88,0x8C -> usage_o=4, ready_o=0. Then ready_i=1 for 4 cycles -> outputs 0x80..0x8C in order, then usage_o=0, valid_o=0.
REQ-035 Wrap-around: 10 push/pop cycles at usage 1 with continuous streaming -> every entry appears exactly once in order, usage_o stays 1, and pointers wrap twice.
REQ-036 Full with simultaneous pop: usage=4, valid_i=1, ready_i=1 -> pop only, usage_o=3; next cycle push plus pop, usage_o stays 3.
REQ-037 Exception hold: push 0x100 (ex.valid=0), then 0x104 (ex.valid=1), then 0x108 offered -> ex_hold_o=1 and ready_o=0, 0x108 is not accepted, and 0x100 and 0x104 still drain. flush_i then gives ready_o=1 and ex_hold_o=0.
REQ-038 Flush mid-stream: usage=3 with flush_i, push and pop all active -> valid_o=0 that cycle and no output handshake; next cycle usage_o=0, and the pushed entry is never output.
REQ-039 Reset mid-operation: usage=2 in EX_HOLD, drive rst_ni=0 for 1 edge -> ready_o=valid_o=0 while low; after release usage_o=0, ex_hold_o=0, ready_o=1.
